// File: rtl/jtag_host_master.sv
// JTAG initiator: turns single-word commands into complete TAP walks (reset, IR/DR scan, idle clocks)
// and returns the captured TDO bits over a valid/ready response channel.
module jtag_host_master #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              tck_o,
   output logic              tms_o,
   output logic              tdi_o,
   input  logic              tdo_i
);

   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_HDR, ST_SHIFT, ST_TRL, ST_RSP} state_t;

   localparam logic [1:0]       OP_TAP_RESET = 2'd0;
   localparam logic [1:0]       OP_SHIFT_IR  = 2'd1;
   localparam logic [1:0]       OP_SHIFT_DR  = 2'd2;
   localparam logic [1:0]       OP_IDLE_CLK  = 2'd3;
   localparam int               IDX_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [7:0]       DIV_LAST     = 8'(CLK_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(DATA_W);

   state_t              state_reg;
   logic                tck_reg, tms_reg, tdi_reg;
   logic                cmd_ready_reg, rsp_valid_reg;
   logic [DATA_W-1:0]   rsp_data_reg;
   logic [7:0]          div_reg;
   logic [LEN_W-1:0]    cnt_reg;
   logic [1:0]          op_reg;
   logic [LEN_W-1:0]    len_reg;
   logic [DATA_W-1:0]   data_reg;

   logic [LEN_W-1:0]    eff_len;
   logic [LEN_W-1:0]    cnt_inc;
   state_t              end_state;
   state_t              accept_state;

   // Number of TCK bits emitted in each walking phase.
   function automatic logic [LEN_W-1:0] bit_count(state_t st, logic [1:0] op, logic [LEN_W-1:0] len);
      case (st)
         ST_INIT:  return LEN_W'(6);
         ST_HDR:   return (op == OP_SHIFT_IR) ? LEN_W'(4) : (op == OP_SHIFT_DR) ? LEN_W'(3) : LEN_W'(6);
         ST_SHIFT: return len;
         ST_TRL:   return LEN_W'(2);
         default:  return LEN_W'(1);
      endcase
   endfunction

   function automatic state_t next_phase(state_t st, logic [1:0] op);
      case (st)
         ST_INIT:  return ST_IDLE;
         ST_HDR:   return (op == OP_TAP_RESET) ? ST_RSP : ST_SHIFT;
         ST_SHIFT: return (op == OP_IDLE_CLK) ? ST_RSP : ST_TRL;
         ST_TRL:   return ST_RSP;
         default:  return ST_IDLE;
      endcase
   endfunction

   // TMS for bit cnt of a phase; IDLE and RSP park at 0 to hold Run-Test/Idle.
   function automatic logic bit_tms(state_t st, logic [1:0] op, logic [LEN_W-1:0] cnt,
                                    logic [LEN_W-1:0] len);
      case (st)
         ST_INIT: return cnt < LEN_W'(5);
         ST_HDR: begin
            case (op)
               OP_SHIFT_IR: return cnt < LEN_W'(2);
               OP_SHIFT_DR: return cnt == '0;
               default:     return cnt < LEN_W'(5);
            endcase
         end
         ST_SHIFT: return (op != OP_IDLE_CLK) && (cnt == len - 1'b1);
         ST_TRL:   return cnt == '0;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic logic bit_tdi(state_t st, logic [1:0] op, logic [LEN_W-1:0] cnt,
                                    logic [DATA_W-1:0] data);
      if (st == ST_SHIFT && (op == OP_SHIFT_IR || op == OP_SHIFT_DR))
         return data[cnt[IDX_W-1:0]];
      return 1'b0;
   endfunction

   assign eff_len      = (cmd_len == '0 || cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
   assign cnt_inc      = cnt_reg + 1'b1;
   assign end_state    = next_phase(state_reg, op_reg);
   assign accept_state = (cmd_op == OP_IDLE_CLK) ? ST_SHIFT : ST_HDR;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_INIT;
         tck_reg       <= 1'b0;
         tms_reg       <= 1'b1;
         tdi_reg       <= 1'b0;
         cmd_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         div_reg       <= '0;
         cnt_reg       <= '0;
         op_reg        <= OP_TAP_RESET;
         len_reg       <= LEN_MAX;
         data_reg      <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready_reg) begin
                  op_reg        <= cmd_op;
                  len_reg       <= eff_len;
                  data_reg      <= cmd_data;
                  cmd_ready_reg <= 1'b0;
                  rsp_data_reg  <= '0;
                  div_reg       <= '0;
                  cnt_reg       <= '0;
                  state_reg     <= accept_state;
                  tms_reg       <= bit_tms(accept_state, cmd_op, '0, eff_len);
                  tdi_reg       <= bit_tdi(accept_state, cmd_op, '0, cmd_data);
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  cmd_ready_reg <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               // TCK engine: low half-period with TMS/TDI settled, then high half-period.
               if (div_reg == DIV_LAST) begin
                  div_reg <= '0;
                  if (!tck_reg) begin
                     tck_reg <= 1'b1;
                     if (state_reg == ST_SHIFT && op_reg != OP_IDLE_CLK)
                        rsp_data_reg[cnt_reg[IDX_W-1:0]] <= tdo_i;
                  end else begin
                     tck_reg <= 1'b0;
                     if (cnt_inc == bit_count(state_reg, op_reg, len_reg)) begin
                        state_reg <= end_state;
                        cnt_reg   <= '0;
                        tms_reg   <= bit_tms(end_state, op_reg, '0, len_reg);
                        tdi_reg   <= bit_tdi(end_state, op_reg, '0, data_reg);
                        if (end_state == ST_IDLE) cmd_ready_reg <= 1'b1;
                        if (end_state == ST_RSP)  rsp_valid_reg <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_inc;
                        tms_reg <= bit_tms(state_reg, op_reg, cnt_inc, len_reg);
                        tdi_reg <= bit_tdi(state_reg, op_reg, cnt_inc, data_reg);
                     end
                  end
               end else begin
                  div_reg <= div_reg + 8'd1;
               end
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign tck_o     = tck_reg;
   assign tms_o     = tms_reg;
   assign tdi_o     = tdi_reg;

endmodule

// File: tb/tb_jtag_host_master.sv
// Directed bench for jtag_host_master: drives commands into a behavioural TAP with a
// bypass register and a 32-bit loopback data register, checking TCK walks and captured TDO.
module tb_jtag_host_master;

   localparam int CLK_DIV = 4;
   localparam int DATA_W  = 32;
   localparam int LEN_W   = 6;

   localparam logic [1:0] OP_RST = 2'd0;
   localparam logic [1:0] OP_IR  = 2'd1;
   localparam logic [1:0] OP_DR  = 2'd2;
   localparam logic [1:0] OP_IDL = 2'd3;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic [DATA_W-1:0] cmd_data = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic              tck_o, tms_o, tdi_o;
   logic              tdo_i = 1'b0;

   int tests = 0;
   int fails = 0;

   jtag_host_master #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i)
   );

   always #5 clk = ~clk;

   // ---------------- TAP model ----------------
   typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UP_DR,
                             SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UP_IR} tap_t;

   function automatic tap_t tap_next(tap_t s, logic t);
      case (s)
         TLR:    return t ? TLR    : RTI;
         RTI:    return t ? SEL_DR : RTI;
         SEL_DR: return t ? SEL_IR : CAP_DR;
         CAP_DR: return t ? EX1_DR : SH_DR;
         SH_DR:  return t ? EX1_DR : SH_DR;
         EX1_DR: return t ? UP_DR  : PA_DR;
         PA_DR:  return t ? EX2_DR : PA_DR;
         EX2_DR: return t ? UP_DR  : SH_DR;
         UP_DR:  return t ? SEL_DR : RTI;
         SEL_IR: return t ? TLR    : CAP_IR;
         CAP_IR: return t ? EX1_IR : SH_IR;
         SH_IR:  return t ? EX1_IR : SH_IR;
         EX1_IR: return t ? UP_IR  : PA_IR;
         PA_IR:  return t ? EX2_IR : PA_IR;
         EX2_IR: return t ? UP_IR  : SH_IR;
         default: return t ? SEL_DR : RTI;
      endcase
   endfunction

   tap_t        tap = TLR;
   logic [4:0]  ir = 5'h01;
   logic [4:0]  ir_sr = '0;
   logic [31:0] dr_sr = '0;
   logic [31:0] loop_reg = 32'hFFFF_FFFC;
   wire         bypass = (ir == 5'h1F);

   always @(posedge tck_o) begin
      case (tap)
         CAP_DR: dr_sr <= bypass ? 32'h0 : loop_reg;
         SH_DR:  if (bypass) dr_sr[0] <= tdi_o; else dr_sr <= {tdi_o, dr_sr[31:1]};
         UP_DR:  if (!bypass) loop_reg <= dr_sr;
         CAP_IR: ir_sr <= 5'b00001;
         SH_IR:  ir_sr <= {tdi_o, ir_sr[4:1]};
         UP_IR:  ir <= ir_sr;
         TLR:    ir <= 5'h01;
         default: ;
      endcase
      tap <= tap_next(tap, tms_o);
   end

   always @(negedge tck_o)
      tdo_i <= (tap == SH_DR) ? dr_sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;

   // ---------------- monitors ----------------
   logic tms_q[$];
   logic tdi_q[$];
   time  rise_q[$];
   time  fall_t = 0;
   int   rsp_seen = 0;

   always @(posedge tck_o) begin
      tms_q.push_back(tms_o);
      tdi_q.push_back(tdi_o);
      rise_q.push_back($time);
   end
   always @(negedge tck_o) fall_t = $time;
   always @(posedge clk) if (rsp_valid) rsp_seen++;

   function automatic logic [63:0] tms_bits(int base, int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n && i < 64; i++) v[i] = tms_q[base + i];
      return v;
   endfunction

   function automatic logic [63:0] tdi_bits(int base, int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n && i < 64; i++) v[i] = tdi_q[base + i];
      return v;
   endfunction

   // ---------------- drivers ----------------
   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s ready_timeout: cmd_ready=%b required 1", tag, cmd_ready);
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                           input logic [31:0] data, input string tag);
      wait_ready(tag);
      cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, output logic [31:0] rsp);
      int n = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL %s rsp_timeout: rsp_valid=%b required 1", tag, rsp_valid);
      end
      rsp = rsp_data;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                          input logic [31:0] data, input string tag,
                          output logic [31:0] rsp, output int base, output int ntck);
      base = tms_q.size();
      rsp_ready = 1'b1;
      send_cmd(op, len, data, tag);
      wait_rsp(tag, rsp);
      ntck = tms_q.size() - base;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s handshake: rsp_valid=%b cmd_ready=%b required 0 1", tag, rsp_valid, cmd_ready);
      end
      $display("[TB] %s op=%0d len=%0d data=%h -> rsp=%h tck=%0d", tag, op, len, data, rsp, ntck);
   endtask

   task automatic check_init_walk(input string tag, input int base, input int seen0);
      int n = tms_q.size() - base;
      int bad = 0;
      tests++;
      if (n !== 6) begin fails++; $display("FAIL %s tck_count: got %0d required 6", tag, n); end
      tests++;
      if (tms_bits(base, 6) !== 64'h1F) begin
         fails++; $display("FAIL %s tms_seq: got %h required 1f", tag, tms_bits(base, 6));
      end
      for (int i = 1; i < n && i < 6; i++)
         if (rise_q[base + i] - rise_q[base + i - 1] != 80) bad++;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL %s tck_period: %0d periods not 80ns", tag, bad); end
      tests++;
      if ($time - fall_t != 5) begin
         fails++; $display("FAIL %s ready_latency: got %0t after last fall required 5", tag, $time - fall_t);
      end
      tests++;
      if (rsp_seen != seen0) begin
         fails++; $display("FAIL %s no_rsp: rsp_valid seen %0d cycles required 0", tag, rsp_seen - seen0);
      end
      tests++;
      if (tap !== RTI) begin fails++; $display("FAIL %s tap_state: got %0d required RTI", tag, tap); end
      $display("[TB] %s init walk tck=%0d tms=%h", tag, n, tms_bits(base, 6));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if ({tck_o, tms_o, tdi_o, cmd_ready, rsp_valid} !== 5'b01000 || rsp_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_values: tck/tms/tdi/rdy/vld=%b rsp=%h required 01000 0",
                  {tck_o, tms_o, tdi_o, cmd_ready, rsp_valid}, rsp_data);
      end
      $display("[TB] reset held, outputs tck=%b tms=%b rdy=%b", tck_o, tms_o, cmd_ready);
   endtask

   task automatic test_init();
      int base = tms_q.size();
      int seen0 = rsp_seen;
      reset_n = 1'b1;
      wait_ready("init");
      check_init_walk("init", base, seen0);
   endtask

   task automatic test_dr_basic();
      logic [31:0] rsp; int base, n;
      run_cmd(OP_DR, 6'd4, 32'h9, "dr4", rsp, base, n);
      tests++;
      if (n !== 9) begin fails++; $display("FAIL dr4 tck_count: got %0d required 9", n); end
      tests++;
      if (tms_bits(base, 9) !== 64'h0C1) begin
         fails++; $display("FAIL dr4 tms_seq: got %h required 0c1", tms_bits(base, 9));
      end
      tests++;
      if (tdi_bits(base + 3, 4) !== 64'h9) begin
         fails++; $display("FAIL dr4 tdi_seq: got %h required 9", tdi_bits(base + 3, 4));
      end
      tests++;
      if (rsp !== 32'hC) begin fails++; $display("FAIL dr4 rsp_data: got %h required 0000000c", rsp); end
      tests++;
      if (tap !== RTI) begin fails++; $display("FAIL dr4 tap_state: got %0d required RTI", tap); end
   endtask

   task automatic test_ir_bypass();
      logic [31:0] rsp; int base, n;
      run_cmd(OP_IR, 6'd5, 32'h1F, "ir_bypass", rsp, base, n);
      tests++;
      if (n !== 11) begin fails++; $display("FAIL ir_bypass tck_count: got %0d required 11", n); end
      tests++;
      if (rsp !== 32'h1) begin fails++; $display("FAIL ir_bypass rsp_data: got %h required 00000001", rsp); end
      tests++;
      if (ir !== 5'h1F) begin fails++; $display("FAIL ir_bypass ir_reg: got %h required 1f", ir); end
      run_cmd(OP_DR, 6'd8, 32'hA5, "dr_bypass", rsp, base, n);
      tests++;
      if (rsp !== 32'h4A) begin fails++; $display("FAIL dr_bypass rsp_data: got %h required 0000004a", rsp); end
      tests++;
      if (n !== 13) begin fails++; $display("FAIL dr_bypass tck_count: got %0d required 13", n); end
   endtask

   task automatic test_dr_full_loop();
      logic [31:0] rsp; int base, n;
      run_cmd(OP_IR, 6'd5, 32'h02, "ir_loop", rsp, base, n);
      tests++;
      if (rsp !== 32'h1) begin fails++; $display("FAIL ir_loop rsp_data: got %h required 00000001", rsp); end
      // len above DATA_W clamps to a full 32-bit scan
      run_cmd(OP_DR, 6'd40, 32'h12345678, "dr_len40", rsp, base, n);
      tests++;
      if (n !== 37) begin fails++; $display("FAIL dr_len40 tck_count: got %0d required 37", n); end
      run_cmd(OP_DR, 6'd0, 32'hDEADBEEF, "dr_len0", rsp, base, n);
      tests++;
      if (n !== 37) begin fails++; $display("FAIL dr_len0 tck_count: got %0d required 37", n); end
      tests++;
      if (rsp !== 32'h12345678) begin fails++; $display("FAIL dr_len0 rsp_data: got %h required 12345678", rsp); end
      tests++;
      if (loop_reg !== 32'hDEADBEEF) begin
         fails++; $display("FAIL dr_len0 target_reg: got %h required deadbeef", loop_reg);
      end
   endtask

   task automatic test_rsp_backpressure();
      logic [31:0] r0; int base; int bad = 0;
      base = tms_q.size();
      rsp_ready = 1'b0;
      send_cmd(OP_DR, 6'd8, 32'h3C, "backpressure");
      wait_rsp("backpressure", r0);
      repeat (20) begin
         @(negedge clk);
         if (tck_o !== 1'b0 || tms_o !== 1'b0 || rsp_data !== r0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL backpressure hold: %0d bad cycles required 0", bad); end
      tests++;
      if (r0 !== 32'hEF) begin fails++; $display("FAIL backpressure rsp_data: got %h required 000000ef", r0); end
      tests++;
      if (tms_q.size() - base !== 13) begin
         fails++; $display("FAIL backpressure tck_count: got %0d required 13", tms_q.size() - base);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++; $display("FAIL backpressure release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
      end
      $display("[TB] backpressure rsp=%h held 20 cycles, bad=%0d", r0, bad);
   endtask

   task automatic test_tap_reset();
      logic [31:0] rsp; int base, n;
      run_cmd(OP_RST, 6'd0, 32'hFFFFFFFF, "tap_reset", rsp, base, n);
      tests++;
      if (n !== 6 || tms_bits(base, 6) !== 64'h1F) begin
         fails++; $display("FAIL tap_reset walk: tck=%0d tms=%h required 6 1f", n, tms_bits(base, 6));
      end
      tests++;
      if (rsp !== 32'h0 || tap !== RTI) begin
         fails++; $display("FAIL tap_reset result: rsp=%h tap=%0d required 0 RTI", rsp, tap);
      end
   endtask

   task automatic test_reset_midscan();
      logic [31:0] rsp; int base, n, seen0; int w = 0;
      base = tms_q.size();
      rsp_ready = 1'b1;
      send_cmd(OP_DR, 6'd32, 32'hCAFEF00D, "midscan");
      while (tms_q.size() - base < 13 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (tms_q.size() - base < 13) begin
         fails++; $display("FAIL midscan progress: tck=%0d required 13", tms_q.size() - base);
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if (tck_o !== 1'b0 || tms_o !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         fails++; $display("FAIL midscan async_reset: tck=%b tms=%b vld=%b rdy=%b required 0 1 0 0",
                           tck_o, tms_o, rsp_valid, cmd_ready);
      end
      repeat (3) @(negedge clk);
      base = tms_q.size();
      seen0 = rsp_seen;
      reset_n = 1'b1;
      wait_ready("reinit");
      check_init_walk("reinit", base, seen0);
      run_cmd(OP_IDL, 6'd10, 32'hFFFFFFFF, "idle_clk", rsp, base, n);
      tests++;
      if (n !== 10) begin fails++; $display("FAIL idle_clk tck_count: got %0d required 10", n); end
      tests++;
      if (tms_bits(base, 10) !== 64'h0 || tdi_bits(base, 10) !== 64'h0) begin
         fails++; $display("FAIL idle_clk pins: tms=%h tdi=%h required 0 0", tms_bits(base, 10), tdi_bits(base, 10));
      end
      tests++;
      if (rsp !== 32'h0) begin fails++; $display("FAIL idle_clk rsp_data: got %h required 00000000", rsp); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_dr_basic();
      test_ir_bypass();
      test_dr_full_loop();
      test_rsp_backpressure();
      test_tap_reset();
      test_reset_midscan();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
